// File: rtl/uart_rx_pkg.sv
// Shared types for the UART receiver: byte type, single-bit type and receiver FSM states.
package uart_rx_pkg;

  localparam int unsigned UART_DATA_BITS = 8;

  typedef logic bit_t;
  typedef logic [UART_DATA_BITS-1:0] fifo_in;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    BREAK
  } uart_rx_state_e;

  // Returns 1 when the byte holds an odd number of ones (the even-parity bit value).
  function automatic bit_t even_parity(input fifo_in d);
    return ^d;
  endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for the asynchronous serial line; resets to the idle (high) level.
module uart_rx_sync (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver with optional even parity; writes good bytes into a FIFO write port
// and keeps sticky framing, parity and overrun flags.
module uart_rx
  import uart_rx_pkg::*;
#(
  parameter int unsigned CLK_PER_BIT = 16,
  parameter bit          PARITY_EN   = 1'b0
) (
  input  logic   uart_clk,
  input  logic   reset,
  input  logic   serial_in,
  input  logic   full,
  input  logic   clear_errors,
  output fifo_in datainput,
  output logic   push,
  output logic   framing_error,
  output logic   parity_error,
  output logic   overrun
);

  localparam int unsigned CntW = $clog2(CLK_PER_BIT);
  localparam int unsigned IdxW = $clog2(UART_DATA_BITS);
  localparam logic [CntW-1:0] HalfLast = CntW'(CLK_PER_BIT / 2 - 1);
  localparam logic [CntW-1:0] BitLast  = CntW'(CLK_PER_BIT - 1);
  localparam logic [IdxW-1:0] IdxLast  = IdxW'(UART_DATA_BITS - 1);

  bit_t rx_s;

  uart_rx_sync u_sync (
    .clk_i  (uart_clk),
    .rst_ni (reset),
    .d_i    (serial_in),
    .q_o    (rx_s)
  );

  uart_rx_state_e  state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [IdxW-1:0] idx_q, idx_d;
  fifo_in          shift_q, shift_d;
  fifo_in          data_q, data_d;
  logic            par_bad_q, par_bad_d;
  logic            push_q, push_d;
  logic            fe_q, fe_d;
  logic            pe_q, pe_d;
  logic            ov_q, ov_d;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    shift_d   = shift_q;
    data_d    = data_q;
    par_bad_d = par_bad_q;
    push_d    = 1'b0;
    // Clear first so that a flag set in the same cycle takes precedence.
    fe_d      = fe_q & ~clear_errors;
    pe_d      = pe_q & ~clear_errors;
    ov_d      = ov_q & ~clear_errors;

    unique case (state_q)
      IDLE: begin
        if (!rx_s) begin
          state_d = START;
          cnt_d   = '0;
        end
      end
      START: begin
        if (cnt_q == HalfLast) begin
          cnt_d = '0;
          if (rx_s) begin
            state_d = IDLE;
          end else begin
            state_d   = DATA;
            idx_d     = '0;
            par_bad_d = 1'b0;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DATA: begin
        if (cnt_q == BitLast) begin
          cnt_d   = '0;
          shift_d = {rx_s, shift_q[UART_DATA_BITS-1:1]};
          if (idx_q == IdxLast) begin
            state_d = PARITY_EN ? PARITY : STOP;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      PARITY: begin
        if (cnt_q == BitLast) begin
          cnt_d     = '0;
          par_bad_d = even_parity(shift_q) ^ rx_s;
          state_d   = STOP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      STOP: begin
        if (cnt_q == BitLast) begin
          cnt_d   = '0;
          state_d = IDLE;
          if (!rx_s) begin
            fe_d    = 1'b1;
            state_d = BREAK;
          end else if (par_bad_q) begin
            pe_d = 1'b1;
          end else if (full) begin
            ov_d = 1'b1;
          end else begin
            push_d = 1'b1;
            data_d = shift_q;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      BREAK: begin
        if (rx_s) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge uart_clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      idx_q     <= '0;
      shift_q   <= '0;
      data_q    <= '0;
      par_bad_q <= 1'b0;
      push_q    <= 1'b0;
      fe_q      <= 1'b0;
      pe_q      <= 1'b0;
      ov_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      shift_q   <= shift_d;
      data_q    <= data_d;
      par_bad_q <= par_bad_d;
      push_q    <= push_d;
      fe_q      <= fe_d;
      pe_q      <= pe_d;
      ov_q      <= ov_d;
    end
  end

  assign datainput     = data_q;
  assign push          = push_q;
  assign framing_error = fe_q;
  assign parity_error  = pe_q;
  assign overrun       = ov_q;

endmodule
